pio_keys_debounce_irq: RTL and testbench

//   Avalon-MM slave parallel input port for the push-button/switch inputs of the audio system.
//   Per-bit input synchroniser and debouncer; readable debounced level; per-bit edge capture.

---
 rtl/pio_keys_debounce_irq.sv | 201 ++++++++++++++++++++
 tb/tb_pio_keys_debounce_irq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_keys_debounce_irq.sv
// ----------------------------------------------------------------------------
// pio_keys_debounce_irq
//
// Avalon-MM slave parallel input port for push-buttons / switches.
// Each input bit is synchronised, debounced independently, and exposed as a
// readable level. Debounced edges (rising, falling or both) are latched in a
// write-1-to-clear edgecapture register which, gated by irqmask, drives a
// level interrupt.
//
// Ports
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous reset, active-low
//   address     in   2      register word address (0 data, 1 irqmask,
//                           2 reserved, 3 edgecapture)
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe, qualified by chipselect
//   writedata   in   32     write data
//   readdata    out  32     registered read data, latency 1, zero when idle
//   in_port     in   WIDTH  raw asynchronous inputs
//   irq         out  1      active-high level interrupt
// ----------------------------------------------------------------------------
module pio_keys_debounce_irq #(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               EDGE_MODE       = 1,
    parameter logic [WIDTH-1:0] IRQMASK_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // A zero debounce time still needs a legal (1-bit) counter type.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    // ------------------------------------------------------------------
    // Input synchroniser: stage 0 samples the raw pins, last stage feeds
    // the debouncers.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-bit debouncer. A bit is accepted only after the synchronised
    // value has disagreed with the accepted level for DEBOUNCE_CYCLES
    // consecutive cycles; any agreement restarts the count.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] stable_w;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic stable_q;
            logic stable_d;

            if (DEBOUNCE_CYCLES == 0) begin : g_bypass
                assign stable_d = sync_s[gi];
            end else begin : g_count
                logic [CNT_W-1:0] cnt_q;
                logic [CNT_W-1:0] cnt_d;

                always_comb begin
                    stable_d = stable_q;
                    cnt_d    = '0;
                    if (sync_s[gi] != stable_q) begin
                        if (cnt_q == CNT_LAST) begin
                            stable_d = sync_s[gi];
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_q <= 1'b0;
                end else begin
                    stable_q <= stable_d;
                end
            end

            assign stable_w[gi] = stable_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection on the debounced level
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] ev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= stable_w;
        end
    end

    generate
        if (EDGE_MODE == 0) begin : g_ev_rise
            assign ev = stable_w & ~prev_q;
        end else if (EDGE_MODE == 1) begin : g_ev_fall
            assign ev = ~stable_w & prev_q;
        end else begin : g_ev_both
            assign ev = stable_w ^ prev_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] clr;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect &  write_n;

    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wdata = ^writedata;

    always_comb begin
        irqmask_d = irqmask_q;
        clr       = '0;
        if (wr_en && (address == 2'd1)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == 2'd3)) begin
            clr = writedata[WIDTH-1:0];
        end
        // A new event in the same cycle as a clear keeps the bit set.
        edgecap_d = ev | (edgecap_q & ~clr);
    end

    // Read mux sees pre-write register state, so a read/write collision
    // is impossible anyway (one strobe per cycle), and bits above WIDTH
    // are always zero.
    always_comb begin
        rd_word = '0;
        case (address)
            2'd0:    rd_word[WIDTH-1:0] = stable_w;
            2'd1:    rd_word[WIDTH-1:0] = irqmask_q;
            2'd3:    rd_word[WIDTH-1:0] = edgecap_q;
            default: rd_word = '0;
        endcase
        readdata_d = rd_en ? rd_word : 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= IRQMASK_RESET;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_keys_debounce_irq.sv
// ----------------------------------------------------------------------------
// tb_pio_keys_debounce_irq
//
// Directed scenarios followed by randomized bus/pin traffic. A behavioural
// model, advanced once per clock by the stimulus process, predicts readdata
// and irq after every edge; predictions go into a queue that an independent
// monitor drains and compares one cycle later.
// ----------------------------------------------------------------------------
module tb_pio_keys_debounce_irq;

    localparam int             W        = 4;
    localparam int             SYNC     = 2;
    localparam int             D        = 8;
    localparam int             EM       = 1;
    localparam logic [W-1:0]   MASK_RST = 4'h0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'h0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port = '0;
    logic          irq;

    always #5 clk = ~clk;

    pio_keys_debounce_irq #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(D),
        .EDGE_MODE(EM), .IRQMASK_RESET(MASK_RST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .in_port(in_port), .irq(irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // scoreboard
    logic [31:0] exp_rd_q[$];
    logic        exp_irq_q[$];
    string       tag_q[$];

    // behavioural model state
    logic [W-1:0] in_val;
    logic [W-1:0] m_stable, m_prev, m_edge, m_mask, m_last_s;
    int           m_run[W];
    logic [W-1:0] m_hist[$];   // the last SYNC pin values, oldest first

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_stable = '0; m_prev = '0; m_edge = '0; m_mask = MASK_RST; m_last_s = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
    endfunction

    function automatic logic [31:0] reg_word(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[W-1:0] = m_stable;
            2'd1: r[W-1:0] = m_mask;
            2'd3: r[W-1:0] = m_edge;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One bus cycle: drive at negedge, predict the state after the next posedge.
    task automatic step(input logic cs, input logic wn, input logic [1:0] a,
                        input logic [31:0] wd, input string tag);
        logic [31:0]  exp_rd;
        logic [W-1:0] ev, clr, s;
        @(negedge clk);
        chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = in_val;
        exp_rd = (cs && wn) ? reg_word(a) : 32'h0;
        case (EM)
            0:       ev = m_stable & ~m_prev;
            1:       ev = ~m_stable & m_prev;
            default: ev = m_stable ^ m_prev;
        endcase
        clr    = (cs && !wn && a == 2'd3) ? wd[W-1:0] : '0;
        m_edge = ev | (m_edge & ~clr);
        if (cs && !wn && a == 2'd1) m_mask = wd[W-1:0];
        m_prev = m_stable;
        // the debouncer sees the pin value from SYNC cycles ago; a bit is
        // accepted once that value has held for D cycles and differs
        s = m_hist.pop_front();
        m_hist.push_back(in_val);
        for (int i = 0; i < W; i++) begin
            if (s[i] == m_last_s[i]) m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : 1000;
            else                     m_run[i] = 1;
            m_last_s[i] = s[i];
            if (s[i] != m_stable[i] && m_run[i] >= D) m_stable[i] = s[i];
        end
        exp_rd_q.push_back(exp_rd);
        exp_irq_q.push_back(|(m_edge & m_mask));
        tag_q.push_back(tag);
    endtask

    task automatic rd(input logic [1:0] a, input string tag);
        step(1'b1, 1'b1, a, 32'h0, tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tag);
        step(1'b1, 1'b0, a, d, tag);
    endtask

    // Asynchronous reset asserted mid-cycle, released mid-cycle.
    task automatic async_reset(input int hold);
        @(posedge clk); #3;
        chipselect = 1'b0; write_n = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        repeat (hold) @(posedge clk);
        #3;
        reset_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compare one prediction after every clock edge that has one.
    initial begin
        string t;
        logic [31:0] e_rd;
        logic e_irq;
        forever begin
            @(posedge clk); #1;
            if (exp_rd_q.size() > 0) begin
                e_rd  = exp_rd_q.pop_front();
                e_irq = exp_irq_q.pop_front();
                t     = tag_q.pop_front();
                chk({t, "_readdata"}, readdata, e_rd);
                chk({t, "_irq"}, {31'h0, irq}, {31'h0, e_irq});
                $display("txn %-10s cs=%b wn=%b a=%0d in=%h rd=%h irq=%b",
                         t, chipselect, write_n, address, in_port, readdata, irq);
            end
        end
    end

    initial begin
        int hold_cnt;
        int r;
        bit found;
        in_val = '0;
        model_reset();

        // power-on reset, released mid-cycle
        repeat (2) @(posedge clk);
        #3;
        chk("por_readdata", readdata, 32'h0);
        chk("por_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        model_reset();

        rd(2'd1, "mask_rst");
        rd(2'd0, "data_rst");

        // glitch shorter than the debounce time must not be accepted
        in_val = 4'h1;
        repeat (7) rd(2'd0, "glitch");
        in_val = 4'h0;
        repeat (12) rd(2'd0, "glitch_dn");
        rd(2'd3, "glitch_ec");

        // clean step on all bits: acceptance latency
        in_val = 4'hF;
        repeat (14) rd(2'd0, "step_up");

        // falling edge on bit2 with irq enabled
        wr(2'd1, 32'h4, "mask4");
        in_val = 4'hB;
        repeat (14) rd(2'd3, "fall2");
        wr(2'd1, 32'h0, "mask0");
        rd(2'd3, "ec_masked");
        rd(2'd1, "mask_rb0");

        // clear racing a new falling event on bit2
        wr(2'd1, 32'h4, "mask4b");
        in_val = 4'hF;
        repeat (14) rd(2'd0, "rise2");
        in_val = 4'hB;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (!m_stable[2] && m_prev[2]) begin
                found = 1'b1;
                break;
            end
            rd(2'd0, "fall2b");
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL race_setup: got no bit2 event expected one within 30 cycles");
        end
        wr(2'd3, 32'h4, "w1c_race");
        rd(2'd3, "ec_after_race");
        wr(2'd3, 32'h4, "w1c");
        rd(2'd3, "ec_cleared");

        // register map: read-only / reserved words, upper bits
        wr(2'd0, 32'hFFFF_FFFF, "wr_data");
        wr(2'd2, 32'hFFFF_FFFF, "wr_resv");
        rd(2'd0, "data_rb");
        rd(2'd2, "resv_rb");
        wr(2'd1, 32'hFFFF_FFFF, "mask_all");
        rd(2'd1, "mask_rbF");
        rd(2'd3, "ec_rb");

        // reset in the middle of a debounce with keys held high
        in_val = 4'h0;
        repeat (14) rd(2'd0, "all_dn");
        in_val = 4'hF;
        repeat (5) rd(2'd0, "mid_deb");
        async_reset(2);
        repeat (14) rd(2'd0, "post_rst");
        rd(2'd1, "mask_rst2");
        rd(2'd3, "ec_rst2");

        // randomized traffic
        hold_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold_cnt == 0) begin
                in_val   = W'($urandom);
                hold_cnt = $urandom_range(1, 14);
            end
            hold_cnt--;
            r = $urandom_range(0, 9);
            if (r <= 5)       rd(2'($urandom), "rnd_rd");
            else if (r == 6)  wr(2'd1, $urandom, "rnd_mask");
            else if (r == 7)  wr(2'd3, $urandom, "rnd_clr");
            else if (r == 8)  wr(2'($urandom), $urandom, "rnd_wr");
            else              step(1'b0, 1'($urandom), 2'($urandom), $urandom, "rnd_idle");
        end

        // drain
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_rd_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_rd_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
